// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between the fetch/execute sequencer and its environment
// (run control, instruction memory read port, phase and status outputs).
interface fetch_ctrl_if #(
   parameter int unsigned ADDR_W = 2,
   parameter int unsigned DATA_W = 2
);
   logic              start;
   logic              halt_req;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic              status;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] ir;
   logic              ir_valid;
   logic              done;
   logic              err;

   modport master (
      input  start, halt_req, mem_ready, mem_rdata,
      output mem_rd, mem_addr, status, pc, ir, ir_valid, done, err
   );

   modport slave (
      output start, halt_req, mem_ready, mem_rdata,
      input  mem_rd, mem_addr, status, pc, ir, ir_valid, done, err
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch/execute sequencer: owns PC and IR, reads memory with a bounded
// ready wait, and drives the fetch/execute status phase bit.
module fetch_ctrl #(
   parameter int unsigned ADDR_W   = 2,
   parameter int unsigned DATA_W   = 2,
   parameter int unsigned WAIT_MAX = 4,
   parameter bit          WRAP     = 1'b0
) (
   input logic         clk,
   input logic         reset,
   fetch_ctrl_if.master bus
);

   typedef enum logic [1:0] {StIdle, StFetch, StExec, StDone} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic              err_q, err_d;
   logic [3:0]        wait_q, wait_d;
   logic [ADDR_W-1:0] operand;

   if (DATA_W >= ADDR_W) begin : g_op
      assign operand = ir_q[ADDR_W-1:0];
   end else begin : g_op_ext
      assign operand = {{(ADDR_W-DATA_W){1'b0}}, ir_q};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         pc_q    <= '0;
         ir_q    <= '0;
         err_q   <= 1'b0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         err_q   <= err_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      err_d   = err_q;
      wait_d  = wait_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               pc_d    = '0;
               err_d   = 1'b0;
               wait_d  = '0;
               state_d = StFetch;
            end
         end
         StFetch: begin
            // A ready on the last allowed wait cycle still wins over the timeout.
            if (bus.mem_ready) begin
               ir_d    = bus.mem_rdata;
               wait_d  = '0;
               state_d = StExec;
            end else if (wait_q == 4'(WAIT_MAX - 1)) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         StExec: begin
            pc_d = pc_q + ADDR_W'(1);
            if (bus.halt_req || (!WRAP && (pc_q == '1))) begin
               state_d = StDone;
            end else begin
               state_d = StFetch;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.mem_rd   = (state_q == StFetch);
      bus.status   = (state_q == StExec);
      bus.ir_valid = (state_q == StExec);
      bus.done     = (state_q == StDone);
      unique case (state_q)
         StFetch: bus.mem_addr = pc_q;
         StExec:  bus.mem_addr = operand;
         default: bus.mem_addr = '0;
      endcase
   end

   assign bus.pc  = pc_q;
   assign bus.ir  = ir_q;
   assign bus.err = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus pushes expected EXEC/DONE events,
// monitors pop and compare them as the DUTs present them.
module tb_fetch_ctrl;

   typedef logic [5:0] exec_t;  // {pc, ir, mem_addr}
   typedef logic [2:0] done_t;  // {pc, err}

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   delay0 = 0;
   bit   never0 = 1'b0;

   logic [1:0] mem [4] = '{2'b01, 2'b10, 2'b11, 2'b00};

   exec_t      q0[$];
   done_t      dq0[$];
   logic [1:0] q1[$];

   fetch_ctrl_if #(.ADDR_W(2), .DATA_W(2)) b0 ();
   fetch_ctrl_if #(.ADDR_W(2), .DATA_W(2)) b1 ();

   fetch_ctrl #(.ADDR_W(2), .DATA_W(2), .WAIT_MAX(4), .WRAP(1'b0)) u0 (
      .clk  (clk),
      .reset(reset),
      .bus  (b0.master)
   );

   fetch_ctrl #(.ADDR_W(2), .DATA_W(2), .WAIT_MAX(4), .WRAP(1'b1)) u1 (
      .clk  (clk),
      .reset(reset),
      .bus  (b1.master)
   );

   assign b0.mem_rdata = mem[b0.mem_addr];
   assign b1.mem_rdata = mem[b1.mem_addr];
   assign b1.mem_ready = 1'b1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory ready responder for u0: ready after delay0 wait cycles, or never.
   initial begin
      int fcnt;
      fcnt = 0;
      b0.mem_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (b0.mem_rd === 1'b1) begin
            if (!never0 && fcnt >= delay0) begin
               b0.mem_ready = 1'b1;
               fcnt = 0;
            end else begin
               b0.mem_ready = 1'b0;
               fcnt++;
            end
         end else begin
            b0.mem_ready = 1'b0;
            fcnt = 0;
         end
      end
   end

   // Monitor for u0.
   initial begin
      logic  dprev;
      exec_t e;
      done_t d;
      dprev = 1'b0;
      forever begin
         @(negedge clk);
         if (b0.ir_valid === 1'b1) begin
            if (q0.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL u0_exec_unexpected: pc=%0d ir=%0b, no EXEC expected", b0.pc, b0.ir);
            end else begin
               e = q0.pop_front();
               check("u0_exec_pc", b0.pc, e[5:4]);
               check("u0_exec_ir", b0.ir, e[3:2]);
               check("u0_exec_addr", b0.mem_addr, e[1:0]);
               check("u0_exec_mem_rd", b0.mem_rd, 0);
            end
         end
         if (b0.done === 1'b1 && !dprev) begin
            if (dq0.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL u0_done_unexpected: pc=%0d err=%0b, no DONE expected", b0.pc, b0.err);
            end else begin
               d = dq0.pop_front();
               check("u0_done_pc", b0.pc, d[2:1]);
               check("u0_done_err", b0.err, d[0]);
            end
         end
         dprev = b0.done;
      end
   end

   // Monitor for u1 (wrapping instance).
   initial begin
      logic [1:0] p;
      forever begin
         @(negedge clk);
         if (b1.ir_valid === 1'b1) begin
            if (q1.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL u1_exec_unexpected: pc=%0d, no EXEC expected", b1.pc);
            end else begin
               p = q1.pop_front();
               check("u1_exec_pc", b1.pc, p);
               check("u1_exec_ir", b1.ir, mem[p]);
               check("u1_no_done", b1.done, 0);
            end
         end
      end
   end

   task automatic push_prog();
      q0.push_back({2'd0, 2'b01, 2'b01});
      q0.push_back({2'd1, 2'b10, 2'b10});
      q0.push_back({2'd2, 2'b11, 2'b11});
      q0.push_back({2'd3, 2'b00, 2'b00});
      dq0.push_back({2'd0, 1'b0});
   endtask

   // Returns on the negedge of the first FETCH cycle.
   task automatic pulse_start0();
      @(negedge clk);
      b0.start = 1'b1;
      @(negedge clk);
      b0.start = 1'b0;
   endtask

   // From the first FETCH negedge: status is 1 on every per-th cycle, DONE after total.
   task automatic run_status(input string nm, input int per, input int total);
      check({nm, "_status"}, b0.status, 0);
      for (int n = 2; n <= total; n++) begin
         @(negedge clk);
         check({nm, "_status"}, b0.status, (n % per == 0));
      end
      @(negedge clk);
      check({nm, "_done"}, b0.done, 1);
      check({nm, "_end_pc"}, b0.pc, 0);
      check({nm, "_end_err"}, b0.err, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      reset       = 1'b1;
      b0.start    = 1'b0;
      b0.halt_req = 1'b0;
      b1.start    = 1'b0;
      b1.halt_req = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_status", b0.status, 0);
      check("rst_mem_rd", b0.mem_rd, 0);
      check("rst_pc", b0.pc, 0);
      check("rst_ir", b0.ir, 0);
      check("rst_ir_valid", b0.ir_valid, 0);
      check("rst_done", b0.done, 0);
      check("rst_err", b0.err, 0);
      check("rst_mem_addr", b0.mem_addr, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_hold", b0.mem_rd, 0);

      // Zero-wait memory: 2 cycles per instruction.
      delay0 = 0;
      push_prog();
      pulse_start0();
      check("t1_fetch_addr", b0.mem_addr, 0);
      run_status("t1", 2, 8);

      // Two wait cycles per fetch: 4 cycles per instruction.
      delay0 = 2;
      push_prog();
      pulse_start0();
      run_status("t2", 4, 16);

      // Ready on the timeout cycle itself: read succeeds, no err.
      delay0 = 3;
      push_prog();
      pulse_start0();
      run_status("t3", 5, 20);

      // Memory never ready: timeout after 4 FETCH cycles.
      never0 = 1'b1;
      dq0.push_back({2'd0, 1'b1});
      pulse_start0();
      for (int n = 1; n <= 4; n++) begin
         if (n > 1) @(negedge clk);
         check("t4_mem_rd", b0.mem_rd, 1);
         check("t4_err_low", b0.err, 0);
      end
      @(negedge clk);
      check("t4_done", b0.done, 1);
      check("t4_err", b0.err, 1);
      check("t4_pc", b0.pc, 0);
      never0 = 1'b0;
      delay0 = 0;
      push_prog();
      pulse_start0();
      check("t4_err_cleared", b0.err, 0);
      check("t4_refetch", b0.mem_rd, 1);
      run_status("t4r", 2, 8);

      // Halt during EXEC of address 1.
      q0.push_back({2'd0, 2'b01, 2'b01});
      q0.push_back({2'd1, 2'b10, 2'b10});
      dq0.push_back({2'd2, 1'b0});
      pulse_start0();
      repeat (3) @(negedge clk);
      check("t5_exec1", b0.status, 1);
      check("t5_exec1_pc", b0.pc, 1);
      b0.halt_req = 1'b1;
      @(negedge clk);
      b0.halt_req = 1'b0;
      check("t5_done", b0.done, 1);
      check("t5_pc", b0.pc, 2);
      push_prog();
      pulse_start0();
      check("t5_restart_pc", b0.pc, 0);
      check("t5_restart_rd", b0.mem_rd, 1);
      run_status("t5r", 2, 8);

      // Reset in the middle of EXEC of address 1; start held during reset.
      q0.push_back({2'd0, 2'b01, 2'b01});
      q0.push_back({2'd1, 2'b10, 2'b10});
      pulse_start0();
      repeat (3) @(negedge clk);
      check("t6_in_exec", b0.status, 1);
      #1;
      reset    = 1'b1;
      b0.start = 1'b1;
      #1;
      check("t6_status", b0.status, 0);
      check("t6_pc", b0.pc, 0);
      check("t6_ir", b0.ir, 0);
      check("t6_ir_valid", b0.ir_valid, 0);
      check("t6_mem_addr", b0.mem_addr, 0);
      repeat (2) @(negedge clk);
      check("t6_start_ignored", b0.mem_rd, 0);
      check("t6_no_done", b0.done, 0);
      reset = 1'b0;
      push_prog();
      @(negedge clk);
      b0.start = 1'b0;
      check("t6_fetch", b0.mem_rd, 1);
      check("t6_fetch_pc", b0.pc, 0);
      run_status("t6r", 2, 8);

      // WRAP=1: 12 instructions, PC 0..3 repeating, halt on the last address.
      for (int i = 0; i < 12; i++) q1.push_back(2'(i % 4));
      @(negedge clk);
      b1.start = 1'b1;
      @(negedge clk);
      b1.start = 1'b0;
      repeat (23) @(negedge clk);
      check("t7_exec_last", b1.status, 1);
      check("t7_exec_last_pc", b1.pc, 3);
      b1.halt_req = 1'b1;
      @(negedge clk);
      b1.halt_req = 1'b0;
      check("t7_done", b1.done, 1);
      check("t7_pc_wrapped", b1.pc, 0);
      check("t7_err", b1.err, 0);

      repeat (2) @(negedge clk);
      check("sb_exec_left", 8'(q0.size()), 0);
      check("sb_done_left", 8'(dq0.size()), 0);
      check("sb_wrap_left", 8'(q1.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
